dmem_lsu: RTL and testbench

- Load/store unit between the single-cycle core's execute stage and the word-only data memory.
- Aligns and sign- or zero-extends LB/LH/LW/LBU/LHU read data.
- Implements SB/SH with a two-cycle read-modify-write and stalls the core for one cycle, because the data memory has no byte enables.
- Flags misaligned accesses and suppresses them.

---
 rtl/dmem_lsu_pkg.sv | 34 +++
 rtl/dmem_lane_mux.sv | 60 ++++++
 rtl/dmem_lsu.sv | 121 ++++++++++++
 tb/tb_dmem_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type,
// and the alignment/legality helpers used by the top level.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  // Halfwords need bit 0 clear, words need both low bits clear; bytes always fit.
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return ~lo[0];
      F3_W:        return (lo == 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

  // Stores only have B/H/W forms; loads additionally have the unsigned variants.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Byte/halfword lane steering: extracts and extends load data, and builds the
// merged word for sub-word stores from the current memory word.
module dmem_lane_mux
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] wdata_lo,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection on the read word.
  always_comb begin
    case (lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign/zero extension of the selected lane; undefined codes read as zero.
  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    load_data = mem_rdata;
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  // Store merge: replace only the target lane of the word just read.
  always_comb begin
    merge_data = mem_rdata;
    case (funct3)
      F3_B: begin
        case (lo)
          2'd0:    merge_data[7:0]   = wdata_lo[7:0];
          2'd1:    merge_data[15:8]  = wdata_lo[7:0];
          2'd2:    merge_data[23:16] = wdata_lo[7:0];
          default: merge_data[31:24] = wdata_lo[7:0];
        endcase
      end
      F3_H: begin
        if (lo[1]) merge_data[31:16] = wdata_lo;
        else       merge_data[15:0]  = wdata_lo;
      end
      default: merge_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-only data memory.
// Sub-word stores become a read (stall) followed by a write of the merged word.
//
// state  | meaning
// IDLE   | accept requests; loads, SW and misaligned/illegal ops finish here
// RMW_WR | write merged word captured during the SB/SH read cycle
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned WORD_AW       = 8,
  parameter bit          MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t         state_q, state_d;
  logic [WORD_AW-1:0] addr_q, addr_d;
  logic [31:0]        merge_q, merge_d;

  logic [1:0]  eff_lo;
  logic        aligned;
  logic        legal;
  logic        go;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Without trapping, the offending low address bits are simply cleared.
  always_comb begin
    eff_lo = addr[1:0];
    if (!MISALIGN_TRAP) begin
      case (funct3)
        F3_H, F3_HU: eff_lo = {addr[1], 1'b0};
        F3_W:        eff_lo = 2'b00;
        default:     eff_lo = addr[1:0];
      endcase
    end
  end

  assign aligned = is_aligned(funct3, addr[1:0]);
  assign legal   = f3_legal(funct3, req_write);
  assign go      = req_valid && legal && (aligned || !MISALIGN_TRAP);

  dmem_lane_mux u_lane_mux (
    .funct3     (funct3),
    .lo         (eff_lo),
    .mem_rdata  (mem_rdata),
    .wdata_lo   (wdata[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Request decode, memory strobes and next-state logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    merge_d      = merge_q;
    rdata        = 32'h0;
    stall        = 1'b0;
    misalign_err = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = {addr[31:2], 2'b00};
    mem_wdata    = wdata;
    case (state_q)
      IDLE: begin
        misalign_err = req_valid && legal && !aligned && MISALIGN_TRAP;
        if (go) begin
          if (!req_write) begin
            mem_read = 1'b1;
            rdata    = load_data;
          end else if (funct3 == F3_W) begin
            mem_write = 1'b1;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            merge_d  = merge_data;
            addr_d   = addr[WORD_AW+1:2];
            state_d  = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // Core is still presenting the same store; ignore it and write back.
        mem_write               = 1'b1;
        mem_addr                = 32'h0;
        mem_addr[WORD_AW+1:2]   = addr_q;
        mem_wdata               = merge_q;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and read-modify-write holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      merge_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-wide combinational-read memory model.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.WORD_AW(8), .MISALIGN_TRAP(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (bd_we)          mem[bd_idx] <= bd_val;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    funct3    = f3;
    addr      = a;
    wdata     = d;
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    bd_we  = 1'b1;
    bd_idx = idx;
    bd_val = val;
    next_cycle();
    bd_we  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bd_we = 1'b0; bd_idx = 8'h0; bd_val = 32'h0;
    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);

    preload(8'd0, 32'h8844_22F1);
    preload(8'd4, 32'hAABB_CCDD);

    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);

    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Loads from 0x8844_22F1
    req(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("lb0_rdata", rdata, 32'hFFFF_FFF1);
    chk("lb0_stall", {31'h0, stall}, 32'h0);
    chk("lb0_mem_read", {31'h0, mem_read}, 32'h1);
    next_cycle();
    req(1'b1, 1'b0, 3'b100, 32'h3, 32'h0);
    chk("lbu3_rdata", rdata, 32'h0000_0088);
    next_cycle();
    req(1'b1, 1'b0, 3'b000, 32'h1, 32'h0);
    chk("lb1_rdata", rdata, 32'h0000_0022);
    next_cycle();
    req(1'b1, 1'b0, 3'b001, 32'h2, 32'h0);
    chk("lh2_rdata", rdata, 32'hFFFF_8844);
    next_cycle();
    req(1'b1, 1'b0, 3'b101, 32'h0, 32'h0);
    chk("lhu0_rdata", rdata, 32'h0000_22F1);
    next_cycle();
    req(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw0_rdata", rdata, 32'h8844_22F1);
    chk("lw0_stall", {31'h0, stall}, 32'h0);
    next_cycle();

    // SB 0x11 <- 0x77 onto 0xAABB_CCDD
    req(1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_0077);
    chk("sb_c1_stall", {31'h0, stall}, 32'h1);
    chk("sb_c1_mem_read", {31'h0, mem_read}, 32'h1);
    chk("sb_c1_mem_write", {31'h0, mem_write}, 32'h0);
    next_cycle();
    chk("sb_c2_mem_write", {31'h0, mem_write}, 32'h1);
    chk("sb_c2_mem_addr", mem_addr, 32'h10);
    chk("sb_c2_mem_wdata", mem_wdata, 32'hAABB_77DD);
    chk("sb_c2_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("sb_readback", rdata, 32'hAABB_77DD);
    chk("sb_readback_stall", {31'h0, stall}, 32'h0);

    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    preload(8'd4, 32'hAABB_CCDD);

    // SH 0x12 <- 0x1234
    req(1'b1, 1'b1, 3'b001, 32'h12, 32'h0000_1234);
    chk("sh_c1_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    chk("sh_c2_mem_write", {31'h0, mem_write}, 32'h1);
    chk("sh_c2_mem_wdata", mem_wdata, 32'h1234_CCDD);
    next_cycle();

    // SW 0x14 single cycle
    req(1'b1, 1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF);
    chk("sw_mem_write", {31'h0, mem_write}, 32'h1);
    chk("sw_stall", {31'h0, stall}, 32'h0);
    chk("sw_mem_read", {31'h0, mem_read}, 32'h0);
    chk("sw_mem_addr", mem_addr, 32'h14);
    chk("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    req(1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    chk("sw_readback", rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Misaligned LW 0x6 and SH 0x5
    req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
    chk("lw6_misalign", {31'h0, misalign_err}, 32'h1);
    chk("lw6_mem_read", {31'h0, mem_read}, 32'h0);
    chk("lw6_stall", {31'h0, stall}, 32'h0);
    chk("lw6_rdata", rdata, 32'h0);
    next_cycle();
    req(1'b1, 1'b1, 3'b001, 32'h5, 32'h0000_5555);
    chk("sh5_misalign", {31'h0, misalign_err}, 32'h1);
    chk("sh5_mem_write", {31'h0, mem_write}, 32'h0);
    chk("sh5_mem_read", {31'h0, mem_read}, 32'h0);
    chk("sh5_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("idle_mem_write", {31'h0, mem_write}, 32'h0);
    chk("idle_mem_read", {31'h0, mem_read}, 32'h0);
    chk("idle_rdata", rdata, 32'h0);
    chk("idle_stall", {31'h0, stall}, 32'h0);
    next_cycle();

    // Undefined funct3
    req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    chk("undef_ld_rdata", rdata, 32'h0);
    chk("undef_ld_misalign", {31'h0, misalign_err}, 32'h0);
    next_cycle();
    req(1'b1, 1'b1, 3'b110, 32'h14, 32'h1111_1111);
    chk("undef_st_mem_write", {31'h0, mem_write}, 32'h0);
    chk("undef_st_stall", {31'h0, stall}, 32'h0);
    next_cycle();

    // Back-to-back SB into a zero word at 0x20
    req(1'b1, 1'b1, 3'b000, 32'h20, 32'h0000_0011);
    chk("b2b_c1_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    chk("b2b_c2_stall", {31'h0, stall}, 32'h0);
    chk("b2b_c2_mem_wdata", mem_wdata, 32'h0000_0011);
    next_cycle();
    req(1'b1, 1'b1, 3'b000, 32'h21, 32'h0000_0022);
    chk("b2b_c3_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    chk("b2b_c4_stall", {31'h0, stall}, 32'h0);
    chk("b2b_c4_mem_wdata", mem_wdata, 32'h0000_2211);
    next_cycle();
    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("b2b_final_word", mem[8], 32'h0000_2211);

    // Reset asserted in the write cycle of an SB
    req(1'b1, 1'b1, 3'b000, 32'h24, 32'h0000_00FF);
    next_cycle();
    chk("rmw_rst_pre_write", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rmw_rst_write_drop", {31'h0, mem_write}, 32'h0);
    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    next_cycle();
    chk("rmw_rst_no_write", mem[9], 32'h0);
    rst_n = 1'b1;
    next_cycle();
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("post_rst_lw_rdata", rdata, 32'h1234_CCDD);
    chk("post_rst_lw_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
